// File: rtl/acc_cpu_gen2.sv
// acc_cpu_gen2 -- parametrised accumulator CPU (fetch / decode / execute).
//
// A multi-cycle accumulator machine that talks to a single memory through a
// req/ready handshake with arbitrary wait states. It also writes a video ring
// that a display scanner reads back.
//
// Ports
//   clock      in   1       single clock, all state updates on posedge
//   reset      in   1       synchronous, active-high
//   mem_rdata  in   DATA_W  read data, valid when mem_ready=1
//   mem_ready  in   1       memory completes the current request this cycle
//   mem_req    out  1       request active; mar/mem_we/mem_wdata held while high
//   mem_we     out  1       1 = write request, 0 = read request
//   mem_wdata  out  DATA_W  write data (acc as seen in DECODE)
//   mar        out  ADDR_W  memory address
//   pc         out  ADDR_W  program counter
//   ir         out  DATA_W  instruction register
//   acc        out  DATA_W  accumulator
//   flag_z     out  1       zero flag
//   flag_c     out  1       carry (ADD) / borrow (SUB)
//   halted     out  1       high in HALT state
module acc_cpu_gen2 #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int RESET_PC  = 0,
  parameter int DATA_BASE = 'hF0,
  parameter int VID_BASE  = 128,
  parameter int VID_LEN   = 80
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mar,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  localparam int OPW = DATA_W - 4;  // operand field width
  localparam int JW  = DATA_W - 1;  // jump target field width

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] DB_ADDR = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] VID_FST = ADDR_W'(VID_BASE);
  localparam logic [ADDR_W-1:0] VID_LST = ADDR_W'(VID_BASE + VID_LEN - 1);

  localparam logic [2:0] OP_LDV = 3'd0;
  localparam logic [2:0] OP_STV = 3'd1;
  localparam logic [2:0] OP_LDI = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd5;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_MWAIT, S_EXEC, S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] vaddr;
  logic [DATA_W-1:0] mdr;

  // Unsigned add with carry out in the top bit.
  function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Unsigned subtract; top bit is 1 when b > a (borrow).
  function automatic logic [DATA_W:0] sub_borrow(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  logic [3:0]        opcode;
  logic              jnz_op;
  logic [2:0]        op3;
  logic [ADDR_W-1:0] op_addr;
  logic [ADDR_W-1:0] jmp_addr;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] ldi_val;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              is_mem;
  logic              is_wr;
  logic              is_vid;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign jnz_op  = opcode[3];
  assign op3     = opcode[2:0];
  assign ldi_val = {4'b0000, ir[OPW-1:0]};
  assign ea      = DB_ADDR + op_addr;
  assign sum     = add_carry(acc, mdr);
  assign diff    = sub_borrow(acc, mdr);

  // Operand and jump fields are zero-extended or truncated to the address width.
  generate
    if (ADDR_W > OPW) begin : g_op_ext
      assign op_addr = {{(ADDR_W-OPW){1'b0}}, ir[OPW-1:0]};
    end else begin : g_op_trunc
      assign op_addr = ir[ADDR_W-1:0];
    end
    if (ADDR_W > JW) begin : g_jmp_ext
      assign jmp_addr = {{(ADDR_W-JW){1'b0}}, ir[JW-1:0]};
    end else begin : g_jmp_trunc
      assign jmp_addr = ir[ADDR_W-1:0];
    end
  endgenerate

  // LDI and HLT need no memory cycle; JNZ (top bit set) never does.
  assign is_mem = !jnz_op && (op3 != OP_LDI) && (op3 != OP_HLT);
  assign is_wr  = !jnz_op && ((op3 == OP_STV) || (op3 == OP_ST));
  assign is_vid = !jnz_op && ((op3 == OP_LDV) || (op3 == OP_STV));

  // Memory data register: pure datapath, loaded on completion of an operand access.
  always_ff @(posedge clock) begin
    if (state == S_MWAIT && mem_ready) mdr <= mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= PC_RST;
      vaddr     <= VID_FST;
      mar       <= '0;
      ir        <= '0;
      acc       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        // Instruction fetch request
        S_FETCH: begin
          mar     <= pc;
          pc      <= pc + 1'b1;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
          state   <= S_FWAIT;
        end
        // Wait for instruction word
        S_FWAIT: begin
          if (mem_ready) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        // Decode: launch operand access or go straight to execute
        S_DECODE: begin
          if (is_mem) begin
            mar       <= is_vid ? vaddr : ea;
            mem_req   <= 1'b1;
            mem_we    <= is_wr;
            mem_wdata <= acc;
            state     <= S_MWAIT;
          end else begin
            state <= S_EXEC;
          end
        end
        // Wait for operand access
        S_MWAIT: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_EXEC;
          end
        end
        // Execute: architectural state update
        S_EXEC: begin
          state <= S_FETCH;
          if (jnz_op) begin
            if (acc != '0) pc <= jmp_addr;
          end else begin
            case (op3)
              OP_LDV, OP_LD: begin
                acc    <= mdr;
                flag_z <= (mdr == '0);
              end
              OP_STV: vaddr <= (vaddr == VID_LST) ? VID_FST : vaddr + 1'b1;
              OP_LDI: begin
                acc    <= ldi_val;
                flag_z <= (ldi_val == '0);
              end
              OP_ADD: begin
                acc    <= sum[DATA_W-1:0];
                flag_c <= sum[DATA_W];
                flag_z <= (sum[DATA_W-1:0] == '0);
              end
              OP_SUB: begin
                acc    <= diff[DATA_W-1:0];
                flag_c <= diff[DATA_W];
                flag_z <= (diff[DATA_W-1:0] == '0);
              end
              OP_HLT: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
              default: ;  // ST: the write already completed in MWAIT
            endcase
          end
        end
        // Halted until reset
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_gen2.sv
// Directed testbench for acc_cpu_gen2: an 8/8 instance with a wait-state
// memory model and a 12/10 instance for wide-field address/jump handling.
module tb_acc_cpu_gen2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // 8-bit instance
  logic [7:0] mem_rdata = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, flag_z, flag_c, halted;
  logic [7:0] mem_wdata, mar, pc, ir, acc;

  // 12-bit data / 10-bit address instance
  logic [11:0] mem_rdata2 = '0;
  logic        mem_ready2 = 1'b0;
  logic        mem_req2, mem_we2, flag_z2, flag_c2, halted2;
  logic [11:0] mem_wdata2, ir2, acc2;
  logic [9:0]  mar2, pc2;

  logic [7:0]  mem1 [256];
  logic [11:0] mem2 [1024];

  int checks   = 0;
  int failures = 0;

  bit   hold      = 1'b0;
  bit   rand_wait = 1'b0;
  bit   seen      = 1'b0;
  int   cnt       = 0;
  int   we_viol   = 0;
  int   stab_viol = 0;
  logic [7:0] st_mar, st_wd;
  logic       st_we;
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];

  always #5 clock = ~clock;

  acc_cpu_gen2 dut (
    .clock(clock), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mar(mar), .pc(pc),
    .ir(ir), .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
  );

  acc_cpu_gen2 #(.DATA_W(12), .ADDR_W(10)) dut2 (
    .clock(clock), .reset(reset), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mar(mar2), .pc(pc2),
    .ir(ir2), .acc(acc2), .flag_z(flag_z2), .flag_c(flag_c2), .halted(halted2)
  );

  // Memory model for the 8-bit instance, driven on the falling edge.
  always @(negedge clock) begin
    if (mem_we && !mem_req) we_viol++;
    if (!mem_req) begin
      seen      = 1'b0;
      mem_ready = 1'b0;
    end else if (hold) begin
      mem_ready = 1'b0;
    end else begin
      if (!seen) begin
        seen   = 1'b1;
        cnt    = rand_wait ? int'($urandom_range(0, 3)) : 0;
        st_mar = mar;
        st_we  = mem_we;
        st_wd  = mem_wdata;
      end else if ({mar, mem_we, mem_wdata} !== {st_mar, st_we, st_wd}) begin
        stab_viol++;
      end
      if (cnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem1[mar];
        if (mem_we) begin
          mem1[mar] = mem_wdata;
          wr_addr.push_back(mar);
          wr_data.push_back(mem_wdata);
        end
      end else begin
        cnt--;
        mem_ready = 1'b0;
      end
    end
  end

  // Zero-wait memory for the wide instance.
  always @(negedge clock) begin
    mem_ready2 = mem_req2;
    mem_rdata2 = mem2[mar2];
    if (mem_req2 && mem_we2) mem2[mar2] = mem_wdata2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rst_on();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic rst_off();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(tag, 32'(halted), 1);
  endtask

  task automatic run_t5(input bit rw, input string pfx);
    rst_on();
    clear_mem();
    mem1[0] = 8'h27;  // LDI 7
    mem1[1] = 8'h32;  // ST [F2]
    mem1[2] = 8'h63;  // SUB [F3]
    mem1[3] = 8'h10;  // STV
    mem1[4] = 8'h42;  // LD [F2]
    mem1[5] = 8'h52;  // ADD [F2]
    mem1[6] = 8'h10;  // STV
    mem1[7] = 8'h00;  // LDV
    mem1[8] = 8'h70;  // HLT
    mem1[8'hF3] = 8'h09;
    rand_wait = rw;
    stab_viol = 0;
    rst_off();
    if (!rw) begin
      edges(14);
      chk({pfx, "_sub_acc"}, 32'(acc), 32'hFE);
      chk({pfx, "_sub_borrow"}, 32'(flag_c), 1);
    end
    wait_halt({pfx, "_halt"}, 400);
    chk({pfx, "_acc"}, 32'(acc), 0);
    chk({pfx, "_z"}, 32'(flag_z), 1);
    chk({pfx, "_c"}, 32'(flag_c), 0);
    chk({pfx, "_pc"}, 32'(pc), 9);
    chk({pfx, "_mF2"}, 32'(mem1[8'hF2]), 7);
    chk({pfx, "_m128"}, 32'(mem1[128]), 32'hFE);
    chk({pfx, "_m129"}, 32'(mem1[129]), 32'h0E);
    chk({pfx, "_stable"}, 32'(stab_viol), 0);
    rand_wait = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad;
    int exp_a;

    for (int i = 0; i < 1024; i++) mem2[i] = 12'h000;
    mem2[0]       = 12'h4FF;  // LD [F0+FF] -> EA 0x1EF
    mem2[1]       = 12'hFA5;  // JNZ, target bits truncate to 0x3A5
    mem2[10'h1EF] = 12'hABC;
    mem2[10'h3A5] = 12'h2C3;  // LDI 0xC3
    mem2[10'h3A6] = 12'h700;  // HLT

    // Reset state
    clear_mem();
    rst_on();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc2", 32'(pc2), 0);

    // T2: LDI 5; ADD [F1]=FC
    clear_mem();
    mem1[0] = 8'h25;
    mem1[1] = 8'h51;
    mem1[2] = 8'h70;
    mem1[8'hF1] = 8'hFC;
    rst_off();
    edges(8);
    chk("t2_acc_e8", 32'(acc), 5);
    edges(1);
    chk("t2_acc_e9", 32'(acc), 1);
    chk("t2_c", 32'(flag_c), 1);
    chk("t2_z", 32'(flag_z), 0);
    chk("t2_pc", 32'(pc), 2);
    wait_halt("t2_halt", 50);

    // T3: SUB to zero, JNZ falls through; then JNZ taken
    rst_on();
    clear_mem();
    mem1[0] = 8'h23;
    mem1[1] = 8'h60;
    mem1[2] = 8'h90;
    mem1[3] = 8'h21;
    mem1[4] = 8'h90;
    mem1[8'h10] = 8'h70;
    mem1[8'hF0] = 8'h03;
    rst_off();
    edges(13);
    chk("t3_pc_fall", 32'(pc), 3);
    chk("t3_acc", 32'(acc), 0);
    chk("t3_z", 32'(flag_z), 1);
    chk("t3_c", 32'(flag_c), 0);
    edges(8);
    chk("t3_pc_jump", 32'(pc), 32'h10);
    wait_halt("t3_halt", 50);
    chk("t3_pc_end", 32'(pc), 32'h11);

    // T1: reset while a write request waits forever
    rst_on();
    clear_mem();
    mem1[0] = 8'h30;  // ST [F0]
    rst_off();
    edges(2);
    hold = 1'b1;
    edges(3);
    chk("t1_req_wait", 32'(mem_req), 1);
    chk("t1_we_wait", 32'(mem_we), 1);
    chk("t1_mar_wait", 32'(mar), 32'hF0);
    @(negedge clock);
    reset = 1'b1;
    edges(1);
    chk("t1_req_rst", 32'(mem_req), 0);
    chk("t1_we_rst", 32'(mem_we), 0);
    chk("t1_pc_rst", 32'(pc), 0);
    chk("t1_no_write", 32'(wr_addr.size()), 0);
    @(negedge clock);
    reset = 1'b0;
    hold = 1'b0;
    edges(1);
    chk("t1_fetch_mar", 32'(mar), 0);
    chk("t1_fetch_pc", 32'(pc), 1);
    chk("t1_fetch_req", 32'(mem_req), 1);

    // T4: 81 STV of 0xAA wrap the video ring
    rst_on();
    clear_mem();
    mem1[0] = 8'h44;  // LD [F4]
    mem1[1] = 8'h10;  // STV
    mem1[2] = 8'h81;  // JNZ 1
    mem1[8'hF4] = 8'hAA;
    we_viol = 0;
    rst_off();
    n = 0;
    while (wr_addr.size() < 81 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("t4_nwrites", 32'(wr_addr.size() >= 81), 1);
    bad = 0;
    for (int i = 0; i < 81; i++) begin
      exp_a = (i < 80) ? 128 + i : 128;
      if (wr_addr[i] !== 8'(exp_a) || wr_data[i] !== 8'hAA) bad++;
    end
    chk("t4_first", 32'(wr_addr[0]), 128);
    chk("t4_last_ring", 32'(wr_addr[79]), 207);
    chk("t4_wrap", 32'(wr_addr[80]), 128);
    chk("t4_bad_writes", 32'(bad), 0);
    chk("t4_we_only_req", 32'(we_viol), 0);

    // T5: same program, zero-wait and random-wait memory
    run_t5(1'b0, "t5z");
    run_t5(1'b1, "t5r");

    // T6: HLT stays quiet, reset restarts
    rst_on();
    clear_mem();
    mem1[0] = 8'h70;
    rst_off();
    edges(4);
    chk("t6_halted", 32'(halted), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      edges(1);
      if (mem_req) n++;
    end
    chk("t6_no_req", 32'(n), 0);
    chk("t6_halted_held", 32'(halted), 1);
    chk("t6_pc", 32'(pc), 1);
    rst_on();
    chk("t6_halted_rst", 32'(halted), 0);
    rst_off();
    edges(1);
    chk("t6_restart_mar", 32'(mar), 0);
    chk("t6_restart_req", 32'(mem_req), 1);

    // Wide instance, running since the same reset release
    edges(4);
    chk("w_acc_ld", 32'(acc2), 32'hABC);
    chk("w_mar_ea", 32'(mar2), 32'h1EF);
    edges(4);
    chk("w_pc_jump", 32'(pc2), 32'h3A5);
    n = 0;
    while (!halted2 && n < 50) begin
      edges(1);
      n++;
    end
    chk("w_halt", 32'(halted2), 1);
    chk("w_acc_ldi", 32'(acc2), 32'h0C3);
    chk("w_pc_end", 32'(pc2), 32'h3A7);
    chk("w_z", 32'(flag_z2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
